output_buffer_ctrl: RTL and testbench

Controller that sequences the dual 1024-bit PIM output buffer.
- Write side: arbitrates capture of the two PIM macro results into their buffer slots. Drives the per-slot write enables, which are never asserted together, and the ack back to each macro.
- Read side: on a host request, drives the buffer read enable and streams the selected 1024-bit result as 32 x 32-bit words over a valid/ready interface toward the RISC-V peripheral bus.
- Tracks per-slot occupancy so unread results are never overwritten.

---
 rtl/output_buffer_pkg.sv | 16 +
 rtl/obuf_wr_arbiter.sv | 63 ++++++
 rtl/output_buffer_ctrl.sv | 142 ++++++++++++++
 tb/tb_output_buffer_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_buffer_pkg.sv
// Shared types and constants for the dual-slot PIM output buffer controller.
package output_buffer_pkg;

  localparam int DEFAULT_DATA_W = 1024;
  localparam int DEFAULT_WORD_W = 32;

  localparam logic SLOT_1 = 1'b0;
  localparam logic SLOT_2 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } rd_state_e;

endpackage

// File: rtl/obuf_wr_arbiter.sv
// Write-side arbiter: round-robin capture of the two PIM macro results into
// their buffer slots, plus the per-slot "holds unread result" flags.
module obuf_wr_arbiter
  import output_buffer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  input  logic [1:0] clr_i,
  output logic [1:0] wen_o,
  output logic [1:0] ack_o,
  output logic [1:0] full_o
);

  logic [1:0] wen_q, wen_d;
  logic [1:0] ack_q, ack_d;
  logic [1:0] full_q, full_d;
  logic       lastGrant_q, lastGrant_d;
  logic [1:0] eligible;
  logic [1:0] grant;

  // A slot may only be granted when it is requested, not holding an unread
  // result and not already in its write cycle; ties go to the slot that was
  // not granted last, and the full flag is set in the same edge as the grant.
  always_comb begin
    eligible    = valid_i & ~full_q & ~wen_q;
    grant       = 2'b00;
    lastGrant_d = lastGrant_q;
    if (eligible == 2'b11) begin
      grant = (lastGrant_q == SLOT_1) ? 2'b10 : 2'b01;
    end else begin
      grant = eligible;
    end
    if (grant[SLOT_2]) begin
      lastGrant_d = SLOT_2;
    end else if (grant[SLOT_1]) begin
      lastGrant_d = SLOT_1;
    end
    wen_d  = grant;
    ack_d  = grant;
    full_d = (full_q & ~clr_i) | grant;
  end

  // Registered enables, acks and occupancy; after reset slot 1 wins a tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wen_q       <= 2'b00;
      ack_q       <= 2'b00;
      full_q      <= 2'b00;
      lastGrant_q <= SLOT_2;
    end else begin
      wen_q       <= wen_d;
      ack_q       <= ack_d;
      full_q      <= full_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  assign wen_o  = wen_q;
  assign ack_o  = ack_q;
  assign full_o = full_q;

endmodule

// File: rtl/output_buffer_ctrl.sv
// Controller for the dual 1024-bit PIM output buffer: write arbitration via
// obuf_wr_arbiter, and a read FSM that streams one slot as 32-bit words.
module output_buffer_ctrl
  import output_buffer_pkg::*;
#(
  parameter  int DATA_W  = DEFAULT_DATA_W,
  parameter  int WORD_W  = DEFAULT_WORD_W,
  localparam int N_WORDS = DATA_W / WORD_W,
  localparam int IDX_W   = $clog2(N_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pim_valid_1_i,
  input  logic             pim_valid_2_i,
  output logic             pim_ack_1_o,
  output logic             pim_ack_2_o,
  output logic             buf_write_en_1_o,
  output logic             buf_write_en_2_o,
  output logic             buf_read_en_o,
  input  logic             rd_req_i,
  input  logic             rd_sel_i,
  output logic             rd_sel_o,
  output logic [IDX_W-1:0] word_idx_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic             rd_done_o,
  output logic             rd_err_o,
  output logic [1:0]       buf_full_o,
  output logic             busy_o
);

  rd_state_e        state_q, state_d;
  logic             rdSel_q, rdSel_d;
  logic [IDX_W-1:0] wordIdx_q, wordIdx_d;
  logic             readEn_q, readEn_d;
  logic             wordValid_q, wordValid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [1:0]       fullClr;
  logic [1:0]       bufFull;
  logic [1:0]       bufWen;
  logic [1:0]       bufAck;

  obuf_wr_arbiter u_wr_arbiter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i ({pim_valid_2_i, pim_valid_1_i}),
    .clr_i   (fullClr),
    .wen_o   (bufWen),
    .ack_o   (bufAck),
    .full_o  (bufFull)
  );

  // Read sequencing: a request to a full, settled slot gets one LOAD cycle
  // to prime the buffer output registers, then words stream out. Read enable
  // stays high throughout STREAM since dropping it zeroes the buffer outputs.
  always_comb begin
    state_d     = state_q;
    rdSel_d     = rdSel_q;
    wordIdx_d   = wordIdx_q;
    readEn_d    = 1'b0;
    wordValid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    fullClr     = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (rd_req_i) begin
          if (bufFull[rd_sel_i] && !bufWen[rd_sel_i]) begin
            state_d   = LOAD;
            rdSel_d   = rd_sel_i;
            wordIdx_d = '0;
            readEn_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        state_d     = STREAM;
        readEn_d    = 1'b1;
        wordValid_d = 1'b1;
      end
      STREAM: begin
        readEn_d    = 1'b1;
        wordValid_d = 1'b1;
        if (wordValid_q && word_ready_i) begin
          wordIdx_d = wordIdx_q + IDX_W'(1);
          if (wordIdx_q == IDX_W'(N_WORDS - 1)) begin
            state_d          = IDLE;
            readEn_d         = 1'b0;
            wordValid_d      = 1'b0;
            done_d           = 1'b1;
            fullClr[rdSel_q] = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Read FSM state and its registered outputs; reset aborts any stream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rdSel_q     <= 1'b0;
      wordIdx_q   <= '0;
      readEn_q    <= 1'b0;
      wordValid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdSel_q     <= rdSel_d;
      wordIdx_q   <= wordIdx_d;
      readEn_q    <= readEn_d;
      wordValid_q <= wordValid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign pim_ack_1_o      = bufAck[SLOT_1];
  assign pim_ack_2_o      = bufAck[SLOT_2];
  assign buf_write_en_1_o = bufWen[SLOT_1];
  assign buf_write_en_2_o = bufWen[SLOT_2];
  assign buf_full_o       = bufFull;
  assign buf_read_en_o    = readEn_q;
  assign rd_sel_o         = rdSel_q;
  assign word_idx_o       = wordIdx_q;
  assign word_valid_o     = wordValid_q;
  assign rd_done_o        = done_q;
  assign rd_err_o         = err_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Self-checking bench for output_buffer_ctrl: directed scenarios plus random
// traffic, all compared against an event/latency-based reference model.
module tb_output_buffer_ctrl;

  localparam int NW = 32;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       pim_valid_1_i = 1'b0;
  logic       pim_valid_2_i = 1'b0;
  logic       pim_ack_1_o;
  logic       pim_ack_2_o;
  logic       buf_write_en_1_o;
  logic       buf_write_en_2_o;
  logic       buf_read_en_o;
  logic       rd_req_i = 1'b0;
  logic       rd_sel_i = 1'b0;
  logic       rd_sel_o;
  logic [4:0] word_idx_o;
  logic       word_valid_o;
  logic       word_ready_i = 1'b0;
  logic       rd_done_o;
  logic       rd_err_o;
  logic [1:0] buf_full_o;
  logic       busy_o;

  output_buffer_ctrl dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .pim_valid_1_i    (pim_valid_1_i),
    .pim_valid_2_i    (pim_valid_2_i),
    .pim_ack_1_o      (pim_ack_1_o),
    .pim_ack_2_o      (pim_ack_2_o),
    .buf_write_en_1_o (buf_write_en_1_o),
    .buf_write_en_2_o (buf_write_en_2_o),
    .buf_read_en_o    (buf_read_en_o),
    .rd_req_i         (rd_req_i),
    .rd_sel_i         (rd_sel_i),
    .rd_sel_o         (rd_sel_o),
    .word_idx_o       (word_idx_o),
    .word_valid_o     (word_valid_o),
    .word_ready_i     (word_ready_i),
    .rd_done_o        (rd_done_o),
    .rd_err_o         (rd_err_o),
    .buf_full_o       (buf_full_o),
    .busy_o           (busy_o)
  );

  // Free-running 10-unit clock.
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit mFull [2];
  bit mAck  [2];
  int mLast;
  bit mActive;
  int mSel;
  int mStart;
  int mIdx;
  bit mDone;
  bit mErr;
  bit vHeld [2];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic void modelReset();
    for (int k = 0; k < 2; k++) begin
      mFull[k] = 1'b0;
      mAck[k]  = 1'b0;
      vHeld[k] = 1'b0;
    end
    mLast   = 1;
    mActive = 1'b0;
    mSel    = 0;
    mStart  = 0;
    mIdx    = 0;
    mDone   = 1'b0;
    mErr    = 1'b0;
    cyc     = 0;
  endfunction

  function automatic bit expReadEn();
    return mActive && (cyc >= mStart + 1);
  endfunction

  function automatic bit expValid();
    return mActive && (cyc >= mStart + 2);
  endfunction

  // Advance the model by one clock given this cycle's inputs.
  function automatic void modelStep(input bit v0, input bit v1, input bit req,
                                    input bit sel, input bit ready);
    bit elig [2];
    bit accept;
    bit lastWord;
    int g;
    bit oldFull [2];
    elig[0]  = v0 && !mFull[0] && !mAck[0];
    elig[1]  = v1 && !mFull[1] && !mAck[1];
    accept   = expValid() && ready;
    lastWord = accept && (mIdx == NW - 1);
    if (elig[0] && elig[1]) g = (mLast == 0) ? 1 : 0;
    else if (elig[0])       g = 0;
    else if (elig[1])       g = 1;
    else                    g = -1;
    oldFull[0] = mFull[0];
    oldFull[1] = mFull[1];
    mDone = 1'b0;
    mErr  = 1'b0;
    if (mActive) begin
      if (accept) begin
        mIdx++;
        if (lastWord) begin
          mActive = 1'b0;
          mDone   = 1'b1;
        end
      end
    end else if (req) begin
      if (oldFull[sel] && !mAck[sel]) begin
        mActive = 1'b1;
        mSel    = int'(sel);
        mStart  = cyc;
        mIdx    = 0;
      end else begin
        mErr = 1'b1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      mFull[k] = (oldFull[k] && !(lastWord && mSel == k)) || (g == k);
      mAck[k]  = (g == k);
    end
    if (g >= 0) mLast = g;
    cyc++;
  endfunction

  task automatic compareAll();
    checkOutput("ack1", pim_ack_1_o, mAck[0]);
    checkOutput("ack2", pim_ack_2_o, mAck[1]);
    checkOutput("wen1", buf_write_en_1_o, mAck[0]);
    checkOutput("wen2", buf_write_en_2_o, mAck[1]);
    checkOutput("wenOverlap", buf_write_en_1_o & buf_write_en_2_o, 0);
    checkOutput("bufFull", buf_full_o, {mFull[1], mFull[0]});
    checkOutput("readEn", buf_read_en_o, expReadEn());
    checkOutput("wordValid", word_valid_o, expValid());
    checkOutput("busy", busy_o, mActive);
    checkOutput("rdDone", rd_done_o, mDone);
    checkOutput("rdErr", rd_err_o, mErr);
    if (mActive) checkOutput("rdSel", rd_sel_o, mSel);
    if (expValid()) checkOutput("wordIdx", word_idx_o, mIdx);
  endtask

  // One clock of stimulus; macros hold valid through their ack cycle.
  task automatic applyStimulus(input bit raise1, input bit raise2, input bit req,
                               input bit sel, input bit ready);
    bit v [2];
    bit r [2];
    r[0] = raise1;
    r[1] = raise2;
    for (int k = 0; k < 2; k++) begin
      if (mAck[k]) begin
        v[k]     = 1'b1;
        vHeld[k] = 1'b0;
      end else begin
        v[k]     = vHeld[k] | r[k];
        vHeld[k] = v[k];
      end
    end
    pim_valid_1_i = v[0];
    pim_valid_2_i = v[1];
    rd_req_i      = req;
    rd_sel_i      = sel;
    word_ready_i  = ready;
    modelStep(v[0], v[1], req, sel, ready);
    @(posedge clk_i);
    #1;
    compareAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic readSlot(input bit sel, input bit toggleReady, input int raiseAt,
                          input bit raise1, input bit raise2);
    int  n;
    bit  rdy;
    n = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, sel, 1'b1);
    while (mActive && n < 200) begin
      rdy = toggleReady ? (n[0] == 1'b0) : 1'b1;
      applyStimulus((n == raiseAt) && raise1, (n == raiseAt) && raise2,
                    (n == raiseAt + 2), ~sel, rdy);
      n++;
    end
  endtask

  task automatic doReset();
    rst_i         = 1'b1;
    pim_valid_1_i = 1'b0;
    pim_valid_2_i = 1'b0;
    rd_req_i      = 1'b0;
    rd_sel_i      = 1'b0;
    word_ready_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    modelReset();
    compareAll();
  endtask

  // Hard time limit so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main scenario sequence.
  initial begin
    int n;
    bit prevReq;
    bit req;
    doReset();

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(2);
    readSlot(1'b0, 1'b1, 5, 1'b1, 1'b1);
    idle(4);
    readSlot(1'b1, 1'b0, 3, 1'b0, 1'b0);
    readSlot(1'b0, 1'b0, 3, 1'b0, 1'b0);
    idle(2);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(4);
    readSlot(1'b0, 1'b0, 40, 1'b0, 1'b0);
    readSlot(1'b1, 1'b0, 40, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(4);

    prevReq = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      req = !prevReq && ($urandom_range(0, 9) == 0);
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, req,
                    1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      prevReq = req;
    end

    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    n = 0;
    while (!(expValid() && mIdx == 7) && n < 50) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    checkOutput("reachIdx7", word_idx_o, 7);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("rstAck1", pim_ack_1_o, 0);
    checkOutput("rstAck2", pim_ack_2_o, 0);
    checkOutput("rstWen1", buf_write_en_1_o, 0);
    checkOutput("rstWen2", buf_write_en_2_o, 0);
    checkOutput("rstReadEn", buf_read_en_o, 0);
    checkOutput("rstRdSel", rd_sel_o, 0);
    checkOutput("rstWordIdx", word_idx_o, 0);
    checkOutput("rstWordValid", word_valid_o, 0);
    checkOutput("rstDone", rd_done_o, 0);
    checkOutput("rstErr", rd_err_o, 0);
    checkOutput("rstFull", buf_full_o, 0);
    checkOutput("rstBusy", busy_o, 0);
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    readSlot(1'b1, 1'b1, 4, 1'b0, 1'b0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
